// File: rtl/mig_regression_checker.sv
// Exhaustive pi/po regression checker: sweeps every input vector, compares po against GOLDEN.
// Optional MIG_CHK_SIGNATURE_EN adds a 16-bit MISR signature of all sampled po values.
module mig_regression_checker #(
  parameter int NUM_PI = 4,
  parameter int NUM_PO = 1,
  parameter logic [(2**NUM_PI)*NUM_PO-1:0] GOLDEN = '0,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [NUM_PI-1:0] pi_vec,
  input  logic [NUM_PO-1:0] po_vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NUM_PI:0]   mismatch_count,
  output logic              first_fail_valid,
  output logic [NUM_PI-1:0] first_fail_vec
`ifdef MIG_CHK_SIGNATURE_EN
  ,
  output logic [15:0]       signature
`endif
);

  // state  | meaning
  // IDLE   | waiting for start; results held
  // SETTLE | pi_vec driven, settle down-counter running
  // SAMPLE | po compared against golden, advance vector
  // DONE   | publish pass, pulse done
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]     SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [NUM_PI-1:0] LAST_IDX    = '1;

  state_t          state;
  logic [CW-1:0]   settle_cnt;
  logic [NUM_PO-1:0] golden_po;
  logic            mismatch;

  // pi_vec doubles as the vector index, so it naturally holds while idle
  assign golden_po = GOLDEN[int'(pi_vec)*NUM_PO +: NUM_PO];
  assign mismatch  = (po_vec != golden_po);

`ifdef MIG_CHK_SIGNATURE_EN
  logic [15:0] po_ext;
  logic [15:0] sig_next;

  always_comb begin
    po_ext = '0;
    po_ext[NUM_PO-1:0] = po_vec;
  end

  assign sig_next = {1'b0, signature[15:1]} ^ (signature[0] ? 16'hB400 : 16'h0000) ^ po_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= 16'h0000;
    end else if (state == IDLE && start && !abort) begin
      signature <= 16'hFFFF;
    end else if (state == SAMPLE && !abort) begin
      signature <= sig_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      pi_vec           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_count   <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            pi_vec           <= '0;
            settle_cnt       <= SETTLE_LOAD;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            pass             <= 1'b0;
            busy             <= 1'b1;
            state            <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= IDLE;
          end else if (settle_cnt == '0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= IDLE;
          end else begin
            if (mismatch) begin
              mismatch_count <= mismatch_count + 1'b1;
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_vec   <= pi_vec;
              end
            end
            if (pi_vec == LAST_IDX) begin
              state <= DONE;
            end else begin
              pi_vec     <= pi_vec + 1'b1;
              settle_cnt <= SETTLE_LOAD;
              state      <= SETTLE;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (mismatch_count == '0);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
